spi_master_arbiter: RTL

Round-robin scheduler that shares the single SPI Master between three on-chip requesters. It accepts one byte-transfer request at a time and drives the Master's start/slaveSelect/masterDataToSend inputs. It times the fixed-length transfer, then captures masterDataReceived and returns it to the winning requester with a done pulse. It sits directly in front of the Master; the Master's SCLK/CS/MOSI/MISO pins are untouched.

---
 rtl/spi_master_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin front end sharing one SPI Master between
// three requesters. Sequences start/slave/tx byte into the Master, times the
// fixed-length transfer, and returns the received byte with a done pulse.
module spi_master_arbiter #(
  parameter int unsigned XFER_CYCLES  = 9,
  parameter int unsigned GUARD_CYCLES = 1,
  parameter int unsigned NUM_SLAVES   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [5:0]  reqSlave,
  input  logic [23:0] reqData,
  output logic [2:0]  ack,
  output logic [2:0]  err,
  output logic [2:0]  done,
  output logic [7:0]  rxData,
  output logic        busy,
  output logic        start,
  output logic [1:0]  slaveSelect,
  output logic [7:0]  masterDataToSend,
  input  logic [7:0]  masterDataReceived
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] GUARD   = 3'd4;

  localparam int unsigned CNT_MAX = (XFER_CYCLES > GUARD_CYCLES) ? XFER_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ptr;
  logic [1:0]       cur;
  logic [2:0]       errQ;
  logic             holdOff;

  logic             winFound;
  logic [1:0]       winIdx;
  logic [1:0]       cand;
  logic [1:0]       winSlave;
  logic [7:0]       winData;
  logic             winValid;

  // Round-robin search starting just after the last winner, wrapping at 3.
  always_comb begin
    winFound = 1'b0;
    winIdx   = 2'd0;
    cand     = 2'd0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = 2'((32'(ptr) + k) % 3);
      if (!winFound && req[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
  end

  // Slave ID and tx byte of the current winner, plus its validity.
  always_comb begin
    winSlave = reqSlave[1:0];
    winData  = reqData[7:0];
    case (winIdx)
      2'd1: begin
        winSlave = reqSlave[3:2];
        winData  = reqData[15:8];
      end
      2'd2: begin
        winSlave = reqSlave[5:4];
        winData  = reqData[23:16];
      end
      default: ;
    endcase
    winValid = {30'd0, winSlave} < NUM_SLAVES;
  end

  // Transfer sequencer. holdOff skips arbitration for the first IDLE cycle
  // after a transfer so the finished requester can react to done before its
  // req is sampled again; this gives the 4+XFER+GUARD grant period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      ptr              <= 2'd2;
      cur              <= 2'd0;
      errQ             <= '0;
      holdOff          <= 1'b0;
      slaveSelect      <= '0;
      masterDataToSend <= '0;
      rxData           <= '0;
    end else begin
      errQ <= '0;
      case (state)
        IDLE: begin
          if (holdOff) begin
            holdOff <= 1'b0;
          end else if (winFound) begin
            ptr <= winIdx;
            if (winValid) begin
              cur              <= winIdx;
              slaveSelect      <= winSlave;
              masterDataToSend <= winData;
              state            <= START;
            end else begin
              errQ <= 3'b001 << winIdx;
            end
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_W'(XFER_CYCLES - 1)) begin
            cnt    <= '0;
            rxData <= masterDataReceived;
            state  <= CAPTURE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          cnt <= '0;
          if (GUARD_CYCLES == 0) begin
            state   <= IDLE;
            holdOff <= 1'b1;
          end else begin
            state <= GUARD;
          end
        end
        GUARD: begin
          if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
            cnt     <= '0;
            state   <= IDLE;
            holdOff <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and Master strobes decoded from the registered state.
  always_comb begin
    start = (state == START);
    busy  = (state != IDLE);
    ack   = (state == START)   ? (3'b001 << cur) : 3'b000;
    done  = (state == CAPTURE) ? (3'b001 << cur) : 3'b000;
    err   = errQ;
  end

endmodule
